// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 16;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ADDR,
    DATA,
    CHECK,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, byte_valid / frame_err pulses.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       st, st_nx;
  logic [1:0]      rx_sync;
  logic            rx_d;
  logic            rx_s;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      bit_idx, bit_nx;
  logic [7:0]      sh, sh_nx;
  logic            bv_nx, fe_nx;

  assign rx_s      = rx_sync[1];
  assign byte_data = sh;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      rx_sync    <= 2'b11;
      rx_d       <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      rx_d       <= rx_s;
      st         <= st_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_nx;
      sh         <= sh_nx;
      byte_valid <= bv_nx;
      frame_err  <= fe_nx;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    bit_nx = bit_idx;
    sh_nx  = sh;
    bv_nx  = 1'b0;
    fe_nx  = 1'b0;
    case (st)
      RX_IDLE: begin
        if (rx_d && !rx_s) begin
          st_nx  = RX_START;
          cnt_nx = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (rx_s) begin
          st_nx = RX_IDLE;
        end else begin
          st_nx  = RX_DATA;
          cnt_nx = CNT_BIT;
          bit_nx = '0;
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          sh_nx  = {rx_s, sh[7:1]};
          cnt_nx = CNT_BIT;
          bit_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) st_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          st_nx = RX_IDLE;
          bv_nx = rx_s;
          fe_nx = !rx_s;
        end
      end
      default: st_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loader.sv
// Loads a framed 16-byte RAM image from UART onto the shared bus (MI/RI strobes), holding the CPU.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mi,
  output logic       ri,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LAST_ADDR = 4'(FRAME_LEN - 1);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .clr        (clr),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  state_t     state, state_nx;
  logic [3:0] addr, addr_nx;
  logic [7:0] data_r, data_nx;
  logic       busy_nx, hold_nx, done_nx, err_nx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum, sum_nx;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      addr     <= '0;
      data_r   <= '0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_nx;
      addr     <= addr_nx;
      data_r   <= data_nx;
      busy     <= busy_nx;
      cpu_hold <= hold_nx;
      done     <= done_nx;
      err      <= err_nx;
`ifdef LOADER_CHECKSUM_EN
      sum      <= sum_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    data_nx  = data_r;
    busy_nx  = busy;
    hold_nx  = cpu_hold;
    done_nx  = done;
    err_nx   = err;
`ifdef LOADER_CHECKSUM_EN
    sum_nx   = sum;
`endif
    bus_out  = 8'h00;
    bus_oe   = 1'b0;
    mi       = 1'b0;
    ri       = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid && rx_byte == SYNC_BYTE) begin
          state_nx = RECV;
          addr_nx  = '0;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          hold_nx  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_nx   = '0;
`endif
        end
      end
      RECV: begin
        if (frame_err) begin
          state_nx = FAIL;
        end else if (byte_valid) begin
          data_nx  = rx_byte;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        bus_oe   = 1'b1;
        bus_out  = {4'h0, addr};
        mi       = 1'b1;
        state_nx = DATA;
      end
      DATA: begin
        bus_oe  = 1'b1;
        bus_out = data_r;
        ri      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_nx  = sum + data_r;
`endif
        // addr stops at the last slot so it never wraps inside a frame
        if (addr == LAST_ADDR) begin
          state_nx = CHECK;
        end else begin
          addr_nx  = addr + 4'd1;
          state_nx = RECV;
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (frame_err || byte_valid) begin
          if (byte_valid && rx_byte == sum) done_nx = 1'b1;
          else                              err_nx  = 1'b1;
          busy_nx  = 1'b0;
          hold_nx  = 1'b0;
          state_nx = IDLE;
        end
`else
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        hold_nx  = 1'b0;
        state_nx = IDLE;
`endif
      end
      FAIL: begin
        err_nx   = 1'b1;
        busy_nx  = 1'b0;
        hold_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized bench for uart_loader: byte-level frame model feeds a write scoreboard checked by a bus monitor.
module tb_uart_loader;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       clr;
  logic       rx;
  logic [7:0] bus_out;
  logic       bus_oe, mi, ri, cpu_hold, busy, done, err;

  uart_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk      (clk),
    .clr      (clr),
    .rx       (rx),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .mi       (mi),
    .ri       (ri),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] ram_exp [16];
  logic [7:0] ram_dut [16];
  int         checks = 0;
  int         errors = 0;

  // reference model of frame acceptance, byte granularity
  bit         m_load, m_done, m_err;
  int         m_idx;
  logic [7:0] m_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_done = 0; m_err = 0; m_idx = 0; m_sum = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (!m_load) begin
      if (stop_ok && b == SYNC) begin
        m_load = 1; m_idx = 0; m_sum = 0; m_done = 0; m_err = 0;
      end
    end else if (!stop_ok) begin
      m_load = 0; m_err = 1;
    end else if (m_idx < 16) begin
      w.addr = 8'(m_idx);
      w.data = b;
      exp_q.push_back(w);
      ram_exp[m_idx] = b;
      m_sum = m_sum + b;
      m_idx++;
`ifndef LOADER_CHECKSUM_EN
      if (m_idx == 16) begin m_load = 0; m_done = 1; end
`endif
    end else begin
      if (b == m_sum) m_done = 1;
      else            m_err  = 1;
      m_load = 0;
    end
  endtask

  // called and returns at a falling clock edge
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    model_byte(b, stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_load(input logic [7:0] d [16], input logic [7:0] ck_delta);
    logic [7:0] s;
    s = 8'h00;
    send_byte(SYNC, 1'b1, $urandom_range(0, 5));
    for (int i = 0; i < 16; i++) begin
      s = s + d[i];
      send_byte(d[i], 1'b1, $urandom_range(0, 5));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s + ck_delta, 1'b1, 2);
`else
    s = s + ck_delta;
`endif
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_bus_out"}, 32'(bus_out), 0);
    chk({nm, "_oe"},      32'(bus_oe), 0);
    chk({nm, "_mi"},      32'(mi), 0);
    chk({nm, "_ri"},      32'(ri), 0);
    chk({nm, "_hold"},    32'(cpu_hold), 0);
    chk({nm, "_busy"},    32'(busy), 0);
    chk({nm, "_done"},    32'(done), 0);
    chk({nm, "_err"},     32'(err), 0);
  endtask

  task automatic check_end(input string nm);
    repeat (12) @(negedge clk);
    chk({nm, "_pending"}, 32'(exp_q.size()), 0);
    chk({nm, "_busy"},    32'(busy), 32'(m_load));
    chk({nm, "_hold"},    32'(cpu_hold), 32'(m_load));
    chk({nm, "_done"},    32'(done), 32'(m_done));
    chk({nm, "_err"},     32'(err), 32'(m_err));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_ram%0d", nm, i), 32'(ram_dut[i]), 32'(ram_exp[i]));
    exp_q.delete();
  endtask

  // bus monitor: pairs each MI with the following RI and pops the scoreboard
  logic [7:0] pend_addr = 8'h00;
  bit         mi_prev   = 0;
  always @(negedge clk) begin
    wr_t e;
    if (mi) begin
      checks++;
      if (ri || !bus_oe || !cpu_hold || !busy) begin
        errors++;
        $display("FAIL strobe_mi: ri=%0b oe=%0b hold=%0b busy=%0b required 0/1/1/1", ri, bus_oe, cpu_hold, busy);
      end
      pend_addr = bus_out;
    end else if (ri) begin
      checks++;
      if (!bus_oe || !mi_prev || !cpu_hold) begin
        errors++;
        $display("FAIL strobe_ri: oe=%0b mi_prev=%0b hold=%0b required 1/1/1", bus_oe, mi_prev, cpu_hold);
      end
      ram_dut[pend_addr[3:0]] = bus_out;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with none expected", pend_addr, bus_out);
      end else begin
        e = exp_q.pop_front();
        if (pend_addr !== e.addr || bus_out !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h", pend_addr, bus_out, e.addr, e.data);
        end
      end
    end else if (bus_oe) begin
      checks++;
      errors++;
      $display("FAIL oe_alone: bus_oe=1 without mi/ri, required 0");
    end
    mi_prev = mi;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [16];
    logic [7:0] noise;
    for (int i = 0; i < 16; i++) begin ram_exp[i] = 8'h00; ram_dut[i] = 8'h00; end
    model_reset();
    clr = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    clr = 1'b1;
    repeat (200) @(negedge clk);
    check_reset("idle");

    // counting image
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    send_load(d, 8'h00);
    check_end("count");
    chk("count_done", 32'(done), 1);

    // non-sync byte ignored before an all-ones image
    send_byte(8'h3C, 1'b1, 3);
    for (int i = 0; i < 16; i++) d[i] = 8'hFF;
    send_load(d, 8'h00);
    check_end("ones");

    // framing error after five bytes
    send_byte(SYNC, 1'b1, 2);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, $urandom_range(0, 4));
    send_byte(8'h55, 1'b0, 12);
    check_end("ferr");
    chk("ferr_err", 32'(err), 1);
    chk("ferr_done", 32'(done), 0);

    // reset after the eighth byte
    send_byte(SYNC, 1'b1, 1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, $urandom_range(0, 4));
    repeat (8) @(negedge clk);
    chk("midrst_pending", 32'(exp_q.size()), 0);
    chk("midrst_hold_before", 32'(cpu_hold), 1);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check_reset("midrst");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    clr = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    send_load(d, 8'h00);
    check_end("after_rst");

    // random frames preceded by random noise bytes
    for (int f = 0; f < 2; f++) begin
      noise = 8'($urandom);
      if (noise == SYNC) noise = 8'h5A;
      send_byte(noise, 1'b1, $urandom_range(0, 6));
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      send_load(d, 8'h00);
      check_end($sformatf("rand%0d", f));
    end

`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 16; i++) d[i] = 8'h01;
    send_load(d, 8'h00);
    check_end("ck_good");
    chk("ck_good_done", 32'(done), 1);
    send_load(d, 8'h01);
    check_end("ck_bad");
    chk("ck_bad_err", 32'(err), 1);
    chk("ck_bad_done", 32'(done), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
